ds1302_time_sched: RTL and testbench
====================================

Name: ds1302_time_sched

Overview:
- Upstream request scheduler for the DS1302 read/write transaction controller, clocked on ds1302_clk.
- Polls the RTC periodically with full-time reads and accepts user set-time commands through a valid/ready handshake.
- Arbitrates the two requests so only one is outstanding, and drives level requests held until the 1-cycle ack.
- Captures read results, masks control bits, checks BCD, and publishes a stable time bus plus an update pulse to display/application logic.

Parameters:
- POLL_CYCLES, 100000, ds1302_clk cycles between periodic reads (min 2).
- TIMEOUT_CYCLES, 1000000, max cycles a request may wait for its ack before abort.

Ports:
- ds1302_clk  in  1  block clock.
- ds1302_rst_n  in  1  asynchronous, active-low reset.
- set_time_valid  in  1  user set-time request.
- set_time  in  56  BCD {year,week,month,date,hour,minute,second}, 8 bits each, second in [7:0].
- set_time_ready  out  1  new set command accepted this cycle if valid.
- write_time_req  out  1  level request to the transaction controller.
- write_time_ack  in  1  1-cycle write completion.
- write_time  out  56  registered write payload, same packing as set_time.
- read_time_req  out  1  level request to the transaction controller.
- read_time_ack  in  1  1-cycle read completion.
- read_time  in  56  raw registers from the controller, same packing; stable when read_time_ack is high.
- time_out  out  56  last masked time.
- time_update  out  1  1-cycle pulse when time_out changes source.
- bcd_err  out  1  last capture contained a nibble >9.
- timeout_err  out  1  sticky abort flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, ds1302_rst_n=0): all outputs 0, state IDLE, poll counter 0, pend_wr 0. Requests drop immediately, including mid-transaction.
- States: IDLE, WR, RD.
- IDLE:
  - poll_cnt increments each cycle; at POLL_CYCLES-1 poll_due is set and poll_cnt holds.
  - set_time_ready = (state==IDLE) and !pend_wr, combinational from registers.
  - On valid&&ready: write_time <= set_time with bit[7] (CH) forced 0 so the oscillator runs; pend_wr <= 1.
  - Next-state priority: pend_wr -> WR; else poll_due -> RD; else stay.
  - Valid and poll_due in the same cycle: the write wins. The post-write read satisfies the poll.
- WR:
  - write_time_req registered 1 on entry; cleared on the edge that samples write_time_ack=1.
  - Then pend_wr <= 0, timeout_err <= 0, go RD (forced refresh).
  - write_time is held constant throughout WR.
- RD:
  - read_time_req registered 1 on entry; cleared on the edge sampling read_time_ack=1.
  - Same edge captures time_out <= read_time with masks: second &7F, minute &7F, hour &3F (24 h mode only), date &3F, month &1F, week &07, year &FF.
  - Same edge: bcd_err <= any masked nibble >9; time_update pulses 1 cycle; timeout_err <= 0; poll_cnt <= 0; poll_due <= 0; go IDLE.
- Both requests are never high in the same cycle. A request never re-asserts in the cycle after its ack, so the controller, returning to its IDLE, sees it low.
- Timeout:
  - to_cnt resets on entry to WR/RD and counts while waiting.
  - At TIMEOUT_CYCLES-1 with no ack: drop the request, set timeout_err, go IDLE.
  - time_out is unchanged on timeout. pend_wr is cleared, so an aborted write is not retried; poll_cnt restarts at 0.
- Acks arriving in IDLE, or the wrong ack type, are ignored with no state change.
- set_time_valid while busy: ready stays 0; the source holds the data.
- Latency: valid accepted to write_time_req high = 1 cycle. poll_due to read_time_req high = 1 cycle.

Test Plan:
- Reset release, POLL_CYCLES=10, read_time=56'h24_03_12_25_93_59_D9, ack 5 cycles after req -> read_time_req rises at cycle 10. time_out=56'h24_03_12_25_13_59_59, time_update one cycle, bcd_err=0.
- set_time_valid with set_time second=8'hB0 in IDLE -> ready high, write_time_req next cycle, write_time[7:0]=8'h30. After write ack, req low next edge, read_time_req asserts one cycle later.
- set_time_valid and poll_due on the same cycle -> exactly one WR then one RD; read_time_req never overlaps write_time_req.
- TIMEOUT_CYCLES=20, no read ack -> req drops at cycle 20, timeout_err=1, time_out unchanged. Next successful read clears timeout_err.
- read_time minute=8'h5A -> bcd_err=1, time_out minute=8'h5A. Spurious read_time_ack in IDLE -> no update pulse.
- ds1302_rst_n low mid-WR -> write_time_req 0 immediately. After release: IDLE, set_time_ready=1, poll restarts from 0.

Source files
------------

// File: rtl/ds1302_time_sched.sv
// ds1302_time_sched: request scheduler in front of the DS1302 transaction
// controller. Polls the RTC with periodic full-time reads, accepts user
// set-time commands, keeps at most one request outstanding, and publishes a
// masked, BCD-checked time bus with a one-cycle update pulse.
module ds1302_time_sched #(
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        ds1302_clk,
    input  logic        ds1302_rst_n,
    input  logic        set_time_valid,
    input  logic [55:0] set_time,
    output logic        set_time_ready,
    output logic        write_time_req,
    input  logic        write_time_ack,
    output logic [55:0] write_time,
    output logic        read_time_req,
    input  logic        read_time_ack,
    input  logic [55:0] read_time,
    output logic [55:0] time_out,
    output logic        time_update,
    output logic        bcd_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned TIME_W  = 56;
    localparam int unsigned NIBBLES = TIME_W / 4;
    localparam int unsigned POLL_W  = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_PRE  = POLL_W'(POLL_CYCLES - 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    // Keeps only the meaningful bits of each RTC register:
    // year FF, week 07, month 1F, date 3F, hour 3F (24 h), minute 7F, second 7F.
    localparam logic [TIME_W-1:0] TIME_MASK = 56'hFF_07_1F_3F_3F_7F_7F;
    // Clears the clock-halt bit (second[7]) so a written time keeps running.
    localparam logic [TIME_W-1:0] CH_CLR    = 56'hFF_FF_FF_FF_FF_FF_7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               armed;
    logic               pend_wr;
    logic               poll_due;
    logic [POLL_W-1:0]  poll_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               accept;
    logic               wr_done;
    logic               rd_done;
    logic               to_hit;
    logic               wreq_d;
    logic               rreq_d;
    logic [TIME_W-1:0]  masked;
    logic               masked_bad;

    // Handshake and completion qualifiers.
    assign set_time_ready = armed && (state == ST_IDLE) && !pend_wr;
    assign accept         = set_time_valid && set_time_ready;
    assign wr_done        = (state == ST_WR) && write_time_req && write_time_ack;
    assign rd_done        = (state == ST_RD) && read_time_req && read_time_ack;
    assign to_hit         = (state != ST_IDLE) && (to_cnt == TO_LAST) && !wr_done && !rd_done;

    // State register.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: a pending or just-accepted write beats a due poll; every
    // write is followed by a refresh read.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (pend_wr || accept) begin
                    state_d = ST_WR;
                end else if (poll_due) begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (wr_done) begin
                    state_d = ST_RD;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (rd_done || to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next request levels; the read request waits one cycle after a write
    // completes so the controller sees both requests low between transactions.
    always_comb begin
        wreq_d = 1'b0;
        rreq_d = 1'b0;
        if (state_d == ST_WR) begin
            wreq_d = 1'b1;
        end
        if ((state_d == ST_RD) && (state != ST_WR)) begin
            rreq_d = 1'b1;
        end
    end

    // Registered request levels and busy flag.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            write_time_req <= 1'b0;
            read_time_req  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            write_time_req <= wreq_d;
            read_time_req  <= rreq_d;
            busy           <= (state_d != ST_IDLE);
        end
    end

    // Holds ready low during the first cycle out of reset.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Write payload capture and pending-write flag.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            write_time <= '0;
            pend_wr    <= 1'b0;
        end else begin
            if (accept) begin
                write_time <= set_time & CH_CLR;
                pend_wr    <= 1'b1;
            end
            if (wr_done || to_hit) begin
                pend_wr <= 1'b0;
            end
        end
    end

    // Poll timer: counts idle cycles, saturates with poll_due set, restarts
    // after a completed or aborted transaction.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            poll_cnt <= '0;
            poll_due <= 1'b0;
        end else if (rd_done || to_hit) begin
            poll_cnt <= '0;
            poll_due <= 1'b0;
        end else if ((state == ST_IDLE) && (poll_cnt != POLL_LAST)) begin
            poll_cnt <= poll_cnt + POLL_W'(1);
            poll_due <= (poll_cnt == POLL_PRE);
        end
    end

    // Ack-wait timer, restarted on every state entry.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            to_cnt <= '0;
        end else if (state_d != state) begin
            to_cnt <= '0;
        end else if (state != ST_IDLE) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Masking and BCD validity of the incoming raw registers.
    always_comb begin
        masked     = read_time & TIME_MASK;
        masked_bad = 1'b0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (masked[i*4 +: 4] > 4'd9) begin
                masked_bad = 1'b1;
            end
        end
    end

    // Published time, status flags and update pulse.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            time_out    <= '0;
            time_update <= 1'b0;
            bcd_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            time_update <= 1'b0;
            if (rd_done) begin
                time_out    <= masked;
                bcd_err     <= masked_bad;
                time_update <= 1'b1;
                timeout_err <= 1'b0;
            end else if (wr_done) begin
                timeout_err <= 1'b0;
            end else if (to_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ds1302_time_sched.sv
// Testbench for ds1302_time_sched: transaction-level reference model checked
// every cycle, a reactive ack responder, and directed literal checks.
module tb_ds1302_time_sched;

    localparam int unsigned P = 10;
    localparam int unsigned T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        set_time_valid = 1'b0;
    logic [55:0] set_time = '0;
    logic        set_time_ready;
    logic        write_time_req;
    logic        write_time_ack;
    logic [55:0] write_time;
    logic        read_time_req;
    logic        read_time_ack;
    logic [55:0] read_time = '0;
    logic [55:0] time_out;
    logic        time_update;
    logic        bcd_err;
    logic        timeout_err;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ds1302_time_sched #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .ds1302_clk     (clk),
        .ds1302_rst_n   (rst_n),
        .set_time_valid (set_time_valid),
        .set_time       (set_time),
        .set_time_ready (set_time_ready),
        .write_time_req (write_time_req),
        .write_time_ack (write_time_ack),
        .write_time     (write_time),
        .read_time_req  (read_time_req),
        .read_time_ack  (read_time_ack),
        .read_time      (read_time),
        .time_out       (time_out),
        .time_update    (time_update),
        .bcd_err        (bcd_err),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    // Ack responder emulating the transaction controller.
    logic rd_en = 1'b1, wr_en = 1'b1;
    int   rd_dly = 5, wr_dly = 3;
    int   rd_cnt = 0, wr_cnt = 0;
    logic rd_auto = 1'b0, wr_auto = 1'b0, rd_man = 1'b0, wr_man = 1'b0;
    assign read_time_ack  = rd_auto | rd_man;
    assign write_time_ack = wr_auto | wr_man;

    always @(negedge clk) begin
        rd_auto <= 1'b0;
        wr_auto <= 1'b0;
        if (!read_time_req || rd_auto) rd_cnt <= 0;
        else if (rd_en) begin
            if (rd_cnt + 1 == rd_dly) begin rd_auto <= 1'b1; rd_cnt <= 0; end
            else rd_cnt <= rd_cnt + 1;
        end
        if (!write_time_req || wr_auto) wr_cnt <= 0;
        else if (wr_en) begin
            if (wr_cnt + 1 == wr_dly) begin wr_auto <= 1'b1; wr_cnt <= 0; end
            else wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [55:0] mask_time(input logic [55:0] raw);
        logic [55:0] r;
        r = raw;
        r[7]     = 1'b0;   // second: clock-halt bit
        r[15]    = 1'b0;   // minute
        r[23:22] = 2'b00;  // hour, 24 h
        r[31:30] = 2'b00;  // date
        r[39:37] = 3'b000; // month
        r[47:43] = 5'b0;   // week
        return r;
    endfunction

    function automatic logic any_bad_digit(input logic [55:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 14; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Reference model: which transaction is outstanding and how long it waited.
    localparam int M_IDLE = 0, M_WR = 1, M_RD = 2;
    int          m_mode, m_idle, m_wait;
    logic        m_armed, m_wreq, m_rreq, m_upd, m_bcd, m_terr;
    logic [55:0] m_wt, m_time;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_idle <= 0; m_wait <= 0; m_armed <= 1'b0;
            m_wreq <= 1'b0; m_rreq <= 1'b0; m_upd <= 1'b0; m_bcd <= 1'b0;
            m_terr <= 1'b0; m_wt <= '0; m_time <= '0;
        end else begin
            m_armed <= 1'b1;
            m_upd   <= 1'b0;
            if (m_mode == M_IDLE) begin
                if (m_idle < int'(P) - 1) m_idle <= m_idle + 1;
                if (set_time_valid && m_armed) begin
                    m_wt <= set_time & ~56'h80;
                    m_mode <= M_WR; m_wreq <= 1'b1; m_wait <= 0;
                end else if (m_idle >= int'(P) - 1) begin
                    m_mode <= M_RD; m_rreq <= 1'b1; m_wait <= 0;
                end
            end else if (m_mode == M_WR && write_time_ack) begin
                m_mode <= M_RD; m_wreq <= 1'b0; m_rreq <= 1'b0; m_wait <= 0; m_terr <= 1'b0;
            end else if (m_mode == M_RD && m_rreq && read_time_ack) begin
                m_time <= mask_time(read_time);
                m_bcd  <= any_bad_digit(mask_time(read_time));
                m_upd  <= 1'b1; m_terr <= 1'b0; m_idle <= 0;
                m_mode <= M_IDLE; m_rreq <= 1'b0;
            end else if (m_wait + 1 == int'(T)) begin
                m_mode <= M_IDLE; m_wreq <= 1'b0; m_rreq <= 1'b0;
                m_terr <= 1'b1; m_idle <= 0;
            end else begin
                m_wait <= m_wait + 1;
                if (m_mode == M_RD) m_rreq <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready",       56'(set_time_ready), 56'(m_armed && m_mode == M_IDLE));
        chk("wr_req",      56'(write_time_req), 56'(m_wreq));
        chk("rd_req",      56'(read_time_req),  56'(m_rreq));
        chk("write_time",  write_time,          m_wt);
        chk("time_out",    time_out,            m_time);
        chk("time_update", 56'(time_update),    56'(m_upd));
        chk("bcd_err",     56'(bcd_err),        56'(m_bcd));
        chk("timeout_err", 56'(timeout_err),    56'(m_terr));
        chk("busy",        56'(busy),           56'(m_mode != M_IDLE));
        chk("req_overlap", 56'(write_time_req && read_time_req), 56'(0));
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return write_time_req;
            1:       return read_time_req;
            2:       return time_update;
            default: return set_time_ready;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (sig(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 56'(sig(sel)), 56'(lvl));
    endtask

    initial begin
        int t0, n, r_rise, w_rise;
        logic pr, pw;
        read_time = 56'h24_03_12_25_93_59_D9;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_time_out", time_out, 56'h0);
        chk("rst_ready",    56'(set_time_ready), 56'(0));
        chk("rst_busy",     56'(busy), 56'(0));
        chk("rst_reqs",     56'({write_time_req, read_time_req}), 56'(0));

        // First poll after reset release.
        rst_n = 1'b1;
        t0 = cyc;
        wait_for(1, 1'b1, 30, "first_poll_req");
        chk("first_poll_cycle", 56'(cyc - t0), 56'(10));
        wait_for(2, 1'b1, 20, "first_update");
        chk("first_time", time_out, 56'h24_03_12_25_13_59_59);
        chk("first_bcd",  56'(bcd_err), 56'(0));
        @(negedge clk);
        chk("update_pulse_1cyc", 56'(time_update), 56'(0));

        // Set time with the clock-halt bit set in the request.
        chk("ready_idle", 56'(set_time_ready), 56'(1));
        read_time = 56'h24_03_12_25_13_59_30;
        set_time_valid = 1'b1;
        set_time = 56'h24_03_12_25_13_59_B0;
        @(negedge clk);
        set_time_valid = 1'b0;
        chk("wr_req_latency", 56'(write_time_req), 56'(1));
        chk("wr_second_ch",   56'(write_time[7:0]), 56'(8'h30));
        chk("wr_payload",     write_time, 56'h24_03_12_25_13_59_30);
        wait_for(0, 1'b0, 20, "wr_ack_drop");
        chk("rd_gap", 56'(read_time_req), 56'(0));
        @(negedge clk);
        chk("rd_after_wr", 56'(read_time_req), 56'(1));
        wait_for(2, 1'b1, 30, "refresh_update");
        chk("refresh_time", time_out, 56'h24_03_12_25_13_59_30);

        // Set-time valid in the same cycle that the poll becomes due.
        repeat (9) @(negedge clk);
        read_time = 56'h25_01_06_15_08_30_00;
        set_time_valid = 1'b1;
        set_time = 56'h25_01_06_15_08_30_00;
        @(negedge clk);
        set_time_valid = 1'b0;
        chk("coll_wr_first", 56'({write_time_req, read_time_req}), 56'(2'b10));
        r_rise = 0; w_rise = 0; n = 0;
        pr = read_time_req; pw = write_time_req;
        while (!time_update && n < 80) begin
            @(negedge clk);
            n++;
            if (read_time_req && !pr) r_rise++;
            if (write_time_req && !pw) w_rise++;
            pr = read_time_req; pw = write_time_req;
        end
        chk("coll_done",    56'(time_update), 56'(1));
        chk("coll_one_rd",  56'(r_rise), 56'(1));
        chk("coll_no_wr2",  56'(w_rise), 56'(0));

        // Read timeout.
        rd_en = 1'b0;
        wait_for(1, 1'b1, 30, "to_req");
        n = 0;
        while (read_time_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", 56'(n), 56'(20));
        chk("to_flag",       56'(timeout_err), 56'(1));
        chk("to_time_kept",  time_out, 56'h25_01_06_15_08_30_00);

        // Recovery read with an invalid minute digit.
        rd_en = 1'b1;
        read_time = 56'h24_03_12_25_13_5A_00;
        wait_for(2, 1'b1, 40, "recover_update");
        chk("to_cleared",  56'(timeout_err), 56'(0));
        chk("bcd_flag",    56'(bcd_err), 56'(1));
        chk("bcd_minute",  56'(time_out[15:8]), 56'(8'h5A));

        // Spurious acks while idle.
        rd_man = 1'b1; wr_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0; wr_man = 1'b0;
        chk("spur_no_upd",  56'(time_update), 56'(0));
        chk("spur_idle",    56'(busy), 56'(0));
        @(negedge clk);
        chk("spur_no_upd2", 56'(time_update), 56'(0));
        chk("spur_time",    time_out, 56'h24_03_12_25_13_5A_00);

        // Reset in the middle of a write.
        wr_en = 1'b0;
        set_time_valid = 1'b1;
        set_time = 56'h26_02_01_01_00_00_00;
        @(negedge clk);
        set_time_valid = 1'b0;
        chk("mid_wr_req", 56'(write_time_req), 56'(1));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_req", 56'(write_time_req), 56'(0));
        chk("rst_busy_low",  56'(busy), 56'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1;
        t0 = cyc;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 56'(set_time_ready), 56'(1));
        wait_for(1, 1'b1, 30, "post_rst_poll");
        chk("post_rst_poll_cycle", 56'(cyc - t0), 56'(10));
        wait_for(2, 1'b1, 20, "post_rst_update");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
